// File: rtl/fp_norm_sequencer.sv
// fp_norm_sequencer: post-add normalization controller.
// Carry right-shift or one-bit-per-cycle left shifts to 1.23 format.
module fp_norm_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inValid,
    output logic        inReady,
    input  logic [25:0] fmInput,
    input  logic [7:0]  expInput,
    input  logic        ovSignal,
    output logic        outValid,
    input  logic        outReady,
    output logic [22:0] Man,
    output logic [7:0]  exp,
    output logic        overflow,
    output logic        underflow,
    output logic [4:0]  shiftCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [25:0] fm_reg;
    logic [7:0]  exp_reg;
    logic        ov_reg;
    logic [4:0]  cnt;

    logic [25:0] fm_sh;
    logic [7:0]  exp_dec;
    logic        eval_done;
    logic        shift_done;

    assign fm_sh   = {fm_reg[24:0], 1'b0};
    assign exp_dec = exp_reg - 8'd1;

    // EVAL finishes without shifting unless a nonzero cancelled
    // fraction with a nonzero exponent needs left shifts.
    assign eval_done = !ov_reg || fm_reg[24] || fm_reg[23] ||
                       (fm_reg[22:0] == 23'd0) || (exp_reg == 8'd0);

    // Stop shifting once the hidden bit is set or the exponent bottoms out.
    assign shift_done = fm_sh[23] || (exp_dec == 8'd0);

    assign inReady    = (state == IDLE);
    assign outValid   = (state == DONE);
    assign shiftCount = cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (inValid) state_nxt = EVAL;
            EVAL:  state_nxt = eval_done ? DONE : SHIFT;
            SHIFT: if (shift_done) state_nxt = DONE;
            DONE:  if (outReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, EVAL decision and shift datapath; results
    // are only written on the way into DONE so they hold there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fm_reg    <= '0;
            exp_reg   <= '0;
            ov_reg    <= 1'b0;
            cnt       <= '0;
            Man       <= '0;
            exp       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (inValid) begin
                        fm_reg    <= fmInput;
                        exp_reg   <= expInput;
                        ov_reg    <= ovSignal;
                        cnt       <= '0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                    end
                end
                EVAL: begin
                    if (!ov_reg) begin
                        Man <= fm_reg[22:0];
                        exp <= exp_reg;
                    end else if (fm_reg[24]) begin
                        if (exp_reg >= 8'd254) begin
                            Man      <= '0;
                            exp      <= 8'd255;
                            overflow <= 1'b1;
                        end else begin
                            Man <= fm_reg[23:1];
                            exp <= exp_reg + 8'd1;
                        end
                    end else if (fm_reg[23]) begin
                        Man <= fm_reg[22:0];
                        exp <= exp_reg;
                    end else if (fm_reg[22:0] == 23'd0) begin
                        Man <= '0;
                        exp <= exp_reg;
                    end else if (exp_reg == 8'd0) begin
                        Man       <= fm_reg[22:0];
                        exp       <= exp_reg;
                        underflow <= 1'b1;
                    end
                end
                SHIFT: begin
                    fm_reg  <= fm_sh;
                    exp_reg <= exp_dec;
                    cnt     <= cnt + 5'd1;
                    if (shift_done) begin
                        Man <= fm_sh[22:0];
                        exp <= exp_dec;
                        if (!fm_sh[23]) underflow <= 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_norm_sequencer.sv
// Bench for fp_norm_sequencer: directed table, handshake/reset
// sequences and randomized operands against a normalization model.
module tb_fp_norm_sequencer;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [25:0] fmInput;
    logic [7:0]  expInput;
    logic        ovSignal;
    logic        outValid;
    logic        outReady;
    logic [22:0] Man;
    logic [7:0]  exp;
    logic        overflow;
    logic        underflow;
    logic [4:0]  shiftCount;

    int checks = 0;
    int errors = 0;

    fp_norm_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inValid    (inValid),
        .inReady    (inReady),
        .fmInput    (fmInput),
        .expInput   (expInput),
        .ovSignal   (ovSignal),
        .outValid   (outValid),
        .outReady   (outReady),
        .Man        (Man),
        .exp        (exp),
        .overflow   (overflow),
        .underflow  (underflow),
        .shiftCount (shiftCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [25:0] fm;
        logic [7:0]  e;
        logic        ov;
        logic [22:0] man;
        logic [7:0]  ex;
        logic        ovf;
        logic        unf;
        logic [4:0]  cnt;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference normalization from the arithmetic rules: locate the
    // leading one, shift by the smaller of its distance and the exponent.
    function automatic vec_t model(input logic [25:0] fm,
                                   input logic [7:0] e, input logic ov);
        vec_t r;
        int msb;
        int lz;
        int k;
        int ei;
        int unsigned t;
        r.fm = fm; r.e = e; r.ov = ov;
        r.man = '0; r.ex = e; r.ovf = 1'b0; r.unf = 1'b0;
        r.cnt = '0; r.lat = 1;
        ei = int'(e);
        if (!ov) begin
            r.man = fm[22:0];
        end else if (fm[24]) begin
            if (ei >= 254) begin
                r.ex = 8'd255; r.ovf = 1'b1;
            end else begin
                r.man = fm[23:1]; r.ex = 8'(ei + 1);
            end
        end else if (fm[23]) begin
            r.man = fm[22:0];
        end else if (fm[22:0] == 23'd0) begin
            r.man = '0;
        end else if (ei == 0) begin
            r.man = fm[22:0]; r.unf = 1'b1;
        end else begin
            msb = 0;
            for (int i = 0; i < 23; i++) if (fm[i]) msb = i;
            lz = 23 - msb;
            k = (lz > ei) ? ei : lz;
            t = {9'd0, fm[22:0]} << k;
            r.man = t[22:0];
            r.ex  = 8'(ei - k);
            r.unf = (lz > ei);
            r.cnt = 5'(k);
            r.lat = 1 + k;
        end
        return r;
    endfunction

    // Issue one operand, wait for the result, check it, optionally take it.
    task automatic apply(input string tag, input vec_t v, input bit take);
        int n;
        @(negedge clk);
        check({tag, " inReady"}, 32'(inReady), 32'd1);
        inValid = 1'b1; fmInput = v.fm; expInput = v.e; ovSignal = v.ov;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        n = 0;
        while (!outValid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (!outValid) begin
            check({tag, " timeout"}, 32'(outValid), 32'd1);
        end else begin
            check({tag, " latency"}, 32'(n), 32'(v.lat));
            check({tag, " Man"}, 32'(Man), 32'(v.man));
            check({tag, " exp"}, 32'(exp), 32'(v.ex));
            check({tag, " overflow"}, 32'(overflow), 32'(v.ovf));
            check({tag, " underflow"}, 32'(underflow), 32'(v.unf));
            check({tag, " shiftCount"}, 32'(shiftCount), 32'(v.cnt));
        end
        if (take) begin
            outReady = 1'b1;
            @(posedge clk);
            @(negedge clk);
            outReady = 1'b0;
            check({tag, " back idle"}, 32'({inReady, outValid}), 32'b10);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " inReady"}, 32'(inReady), 32'd1);
        check({tag, " outValid"}, 32'(outValid), 32'd0);
        check({tag, " outs"},
              32'({Man, exp, overflow} | 32'({underflow, shiftCount})),
              32'd0);
    endtask

    initial begin
        vec_t v;
        logic [7:0] e;
        rst_n = 1'b0; inValid = 1'b0; fmInput = '0; expInput = '0;
        ovSignal = 1'b0; outReady = 1'b0;

        vecs[0]  = '{26'h1000000, 8'd100, 1'b1, 23'h0, 8'd101, 1'b0, 1'b0, 5'd0, 1};
        vecs[1]  = '{26'h0400000, 8'd100, 1'b1, 23'h0, 8'd99, 1'b0, 1'b0, 5'd1, 2};
        vecs[2]  = '{26'h0000001, 8'd100, 1'b1, 23'h0, 8'd77, 1'b0, 1'b0, 5'd23, 24};
        vecs[3]  = '{26'h1800000, 8'd254, 1'b1, 23'h0, 8'd255, 1'b1, 1'b0, 5'd0, 1};
        vecs[4]  = '{26'h0000001, 8'd5, 1'b1, 23'h20, 8'd0, 1'b0, 1'b1, 5'd5, 6};
        vecs[5]  = '{26'h0ABCDEF, 8'd7, 1'b0, 23'h2BCDEF, 8'd7, 1'b0, 1'b0, 5'd0, 1};
        vecs[6]  = '{26'h0000000, 8'd42, 1'b1, 23'h0, 8'd42, 1'b0, 1'b0, 5'd0, 1};
        vecs[7]  = '{26'h1000003, 8'd253, 1'b1, 23'h1, 8'd254, 1'b0, 1'b0, 5'd0, 1};
        vecs[8]  = '{26'h0800000, 8'd0, 1'b1, 23'h0, 8'd0, 1'b0, 1'b0, 5'd0, 1};
        vecs[9]  = '{26'h0000010, 8'd0, 1'b1, 23'h10, 8'd0, 1'b0, 1'b1, 5'd0, 1};
        vecs[10] = '{26'h1000000, 8'd255, 1'b1, 23'h0, 8'd255, 1'b1, 1'b0, 5'd0, 1};
        vecs[11] = '{26'h0000003, 8'd22, 1'b1, 23'h400000, 8'd0, 1'b0, 1'b0, 5'd22, 23};

        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            apply($sformatf("vec%0d", i), vecs[i], 1'b1);
        end

        // Result held for 10 cycles while further operands are offered.
        v = model(26'h0000100, 8'd50, 1'b1);
        apply("hold", v, 1'b0);
        for (int c = 0; c < 10; c++) begin
            inValid = 1'b1; fmInput = 26'h1FFFFFF; expInput = 8'd3;
            ovSignal = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("hold state", 32'({inReady, outValid}), 32'b01);
            check("hold Man/exp", 32'({Man, exp}), 32'({v.man, v.ex}));
            check("hold cnt", 32'({shiftCount, underflow, overflow}),
                  32'({v.cnt, v.unf, v.ovf}));
        end
        inValid = 1'b0;
        outReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outReady = 1'b0;
        check("hold release", 32'({inReady, outValid}), 32'b10);
        apply("after hold", vecs[1], 1'b1);

        // Asynchronous reset in the middle of a long shift sequence.
        @(negedge clk);
        inValid = 1'b1; fmInput = 26'h0000001; expInput = 8'd100;
        ovSignal = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        apply("after reset", vecs[4], 1'b1);

        // Randomized operands against the model.
        for (int r = 0; r < 200; r++) begin
            logic [25:0] fm;
            logic        ov;
            fm = 26'($urandom) >> $urandom_range(0, 25);
            ov = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 2))
                0: e = 8'($urandom_range(0, 255));
                1: e = 8'($urandom_range(0, 25));
                default: e = 8'($urandom_range(250, 255));
            endcase
            v = model(fm, e, ov);
            apply($sformatf("rand%0d", r), v, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
